// File: rtl/pcihellocore_key_input.sv
// pcihellocore_key_input: debounced active-low key port with press capture, counter and maskable irq
module pcihellocore_key_input #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, deb, deb_nxt, press, mask, edge_bits, clr;
  logic [CW-1:0] cnt [WIDTH];
  logic [CW-1:0] cnt_nxt [WIDTH];
  logic [15:0] press_cnt;
  logic wr, unused_wd;
  assign wr = chipselect && !write_n;
  assign unused_wd = ^writedata[31:WIDTH];
  assign clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  // a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      deb_nxt[i] = (s2[i] != deb[i] && cnt[i] == LAST) ? s2[i] : deb[i];
      cnt_nxt[i] = (s2[i] == deb[i] || cnt[i] == LAST) ? '0 : cnt[i] + CW'(1);
    end
  end
  assign press = deb & ~deb_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '1;
      cnt <= '{default: '0};
      mask <= '0;
      edge_bits <= '0;
      press_cnt <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      deb <= deb_nxt;
      cnt <= cnt_nxt;
      if (wr && address == 2'd1) mask <= writedata[WIDTH-1:0];
      edge_bits <= (edge_bits & ~clr) | press;
      press_cnt <= (wr && address == 2'd3) ? '0 : press_cnt + 16'(|press);
    end
  end
  always_comb
    readdata = address == 2'd0 ? 32'(deb) :
               address == 2'd1 ? 32'(mask) :
               address == 2'd2 ? 32'(edge_bits) : 32'(press_cnt);
  assign irq = |(edge_bits & mask);
endmodule

// File: tb/tb_pcihellocore_key_input.sv
// tb_pcihellocore_key_input: scoreboard bench against a sample-history reference model
module tb_pcihellocore_key_input;
  localparam int W = 4;
  localparam int N = 4;
  logic clk = 0;
  logic reset = 1;
  logic chipselect = 0;
  logic write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = '1;
  logic [31:0] readdata;
  logic irq;
  int total = 0;
  int bad = 0;
  logic rq = 0;
  logic rq_const = 0;
  logic rq_irq = 0;
  logic [31:0] rq_val = 0;
  logic [W-1:0] m_deb = '1;
  logic [W-1:0] m_mask = 0;
  logic [W-1:0] m_edge = 0;
  logic [15:0] m_cnt = 0;
  logic [W-1:0] hist[$];
  logic [31:0] exp_d[$];
  logic exp_i[$];
  logic [1:0] exp_a[$];

  pcihellocore_key_input #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    return a == 0 ? 32'(m_deb) : a == 1 ? 32'(m_mask) : a == 2 ? 32'(m_edge) : 32'(m_cnt);
  endfunction

  task automatic model_step();
    logic [W-1:0] nd, pr;
    logic wr, same;
    int sz;
    wr = chipselect && !write_n;
    if (reset) begin
      hist[hist.size()-1] = '1;
      hist.push_back('1);
      m_deb = '1;
      m_mask = 0;
      m_edge = 0;
      m_cnt = 0;
    end else begin
      hist.push_back(in_port);
      sz = hist.size();
      nd = m_deb;
      for (int i = 0; i < W; i++) begin
        same = 1;
        for (int k = 2; k <= N + 1; k++) if (hist[sz-1-k][i] == m_deb[i]) same = 0;
        if (same) nd[i] = ~m_deb[i];
      end
      pr = m_deb & ~nd;
      if (wr && address == 1) m_mask = writedata[W-1:0];
      m_edge = ((wr && address == 2) ? (m_edge & ~writedata[W-1:0]) : m_edge) | pr;
      m_cnt = (wr && address == 3) ? 16'h0 : m_cnt + 16'(pr != 0);
      m_deb = nd;
    end
    if (hist.size() > 16) void'(hist.pop_front());
    if (rq) begin
      exp_a.push_back(address);
      exp_d.push_back(rq_const ? rq_val : m_read(address));
      exp_i.push_back(rq_const ? rq_irq : |(m_edge & m_mask));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [31:0] ed;
    logic ei;
    logic [1:0] ea;
    @(posedge clk);
    #2;
    if (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      ei = exp_i.pop_front();
      ea = exp_a.pop_front();
      total++;
      if (readdata !== ed || irq !== ei) begin
        bad++;
        $display("FAIL rd addr=%0d data got=%h exp=%h irq got=%b exp=%b t=%0t", ea, readdata, ed, irq, ei, $time);
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: test did not finish t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic slot(input logic c, input logic wn, input logic [1:0] a, input logic [31:0] d,
                      input logic r, input logic rc, input logic [31:0] rv, input logic ri);
    chipselect = c;
    write_n = wn;
    address = a;
    writedata = d;
    rq = r;
    rq_const = rc;
    rq_val = rv;
    rq_irq = ri;
    @(negedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) slot(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    slot(1, 1, a, 0, 1, 0, 0, 0);
  endtask

  task automatic chk(input logic [1:0] a, input logic [31:0] v, input logic i);
    slot(1, 1, a, 0, 1, 1, v, i);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    slot(1, 0, a, d, 0, 0, 0, 0);
  endtask

  task preload();
    chipselect = 0;
    write_n = 1;
    rq = 0;
    force dut.press_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    #1;
    release dut.press_cnt;
  endtask

  initial begin
    int hold;
    hold = 0;
    repeat (16) hist.push_back('1);
    @(negedge clk);
    #1;
    nop(3);
    total++;
    if (readdata !== 32'hF || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset state: data got=%h exp=0000000f irq got=%b exp=0 t=%0t", readdata, irq, $time);
    end
    reset = 0;
    chk(0, 32'hF, 0);
    chk(1, 0, 0);
    chk(2, 0, 0);
    chk(3, 0, 0);
    wr(1, 1);
    in_port = 4'hE;
    repeat (4) rd(0);
    chk(0, 32'hF, 0);
    chk(0, 32'hE, 1);
    chk(2, 1, 1);
    chk(3, 1, 1);
    wr(2, 1);
    chk(2, 0, 0);
    in_port = '1;
    nop(7);
    chk(0, 32'hF, 0);
    chk(2, 0, 0);
    chk(3, 1, 0);
    in_port = 4'hB;
    nop(3);
    in_port = '1;
    repeat (8) rd(0);
    chk(0, 32'hF, 0);
    chk(2, 0, 0);
    chk(3, 1, 0);
    in_port = 4'h5;
    repeat (6) rd(2);
    chk(2, 32'hA, 0);
    chk(3, 2, 0);
    in_port = '1;
    nop(7);
    chk(2, 32'hA, 0);
    chk(3, 2, 0);
    wr(2, 32'hF);
    preload();
    in_port = 4'hE;
    nop(5);
    chk(3, 0, 1);
    in_port = '1;
    nop(7);
    wr(2, 32'hF);
    in_port = 4'hE;
    nop(5);
    chk(3, 1, 1);
    in_port = '1;
    nop(7);
    wr(2, 32'hF);
    in_port = 4'hE;
    nop(5);
    wr(3, 0);
    chk(3, 0, 1);
    in_port = '1;
    nop(7);
    wr(2, 32'hF);
    in_port = 4'hE;
    nop(5);
    wr(2, 1);
    chk(2, 1, 1);
    chk(3, 1, 1);
    in_port = '1;
    nop(7);
    wr(2, 32'hF);
    chk(2, 0, 0);
    in_port = 4'hE;
    nop(2);
    reset = 1;
    nop(2);
    reset = 0;
    chk(1, 0, 0);
    chk(2, 0, 0);
    chk(3, 0, 0);
    rd(0);
    chk(0, 32'hF, 0);
    chk(0, 32'hE, 0);
    chk(2, 1, 0);
    chk(3, 1, 0);
    in_port = '1;
    nop(7);
    for (int s = 0; s < 300; s++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 9) < 8) rd(2'($urandom));
      else wr(2'($urandom), $urandom);
    end
    nop(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcihellocore_key_input.md
# pcihellocore_key_input

Avalon-MM slave input port for the Morse keying pushbuttons. It carries data from the board to the host, the opposite direction of the hex-display output port. Each pushbutton line is synchronized, debounced, and presented to the host through a register map alongside a per-bit press (edge) capture, a press counter and a maskable interrupt. It sits on the same PCI-to-Avalon bridge as the display port, and the host driver polls or takes IRQs from it to time Morse dots and dashes.

## Interface
- WIDTH, 4: number of key lines (1..16).
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a level change (>= 1).
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- address  input  2  register select (word address).
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write is chipselect && !write_n.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw key lines, asynchronous, active-low (1 = released).
- readdata  output  32  read data; zero read latency, no wait states.
- irq  output  1  active-high interrupt request.

## Operation
- Synchronizer: two flops per bit (s1, s2), reset to all-ones.
- Debounce, per bit i, with deb[i] reset to 1 and cnt[i] reset to 0, width $clog2(DEBOUNCE_CYCLES) with a minimum of 1:
  - If s2[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch back to deb[i] restarts the count.
- Press event on bit i: deb[i] transitions 1->0. Release (0->1) generates no event.
- Register map (unused upper readdata bits read 0):
  - 0 DATA (RO): deb. Writes are ignored.
  - 1 MASK (RW): irq mask, bits WIDTH-1:0. Reset value 0.
  - 2 EDGE (R/W1C): edge[i] sets on a press event on bit i. Writing 1 to bit i clears it. Reset value 0.
  - 3 COUNT (R/W): 16-bit press counter in readdata[15:0]. Increments by 1 in each cycle with at least one press event, even if several bits press together. Wraps 0xFFFF->0x0000. Any write clears it to 0.
- readdata is a combinational mux of the registered state on address and is driven regardless of chipselect. Reads have no side effects.
- irq = |(edge & mask), combinational from registers.
- Simultaneous W1C and a new press event on the same edge bit: the set wins and the bit stays 1.
- Simultaneous COUNT write and press event: the write wins and COUNT becomes 0.
- MASK changes affect irq in the same cycle the register updates. EDGE bits set regardless of MASK.

## Timing
- Reset (sampled on a clk edge):
  - s1, s2 and deb go to all-ones. cnt, MASK, EDGE and COUNT go to 0.
  - irq = 0. readdata then reads DATA = 2^WIDTH-1 at address 0 and 0 at addresses 1-3.
- Let edge E be the first clk edge at which s1 samples a new in_port value, held stable afterwards. deb updates at edge E+DEBOUNCE_CYCLES+1.
- EDGE bit and COUNT update at the same edge as deb. irq rises in the following cycle with no extra register stage.
- Register writes take effect at the clk edge where chipselect && !write_n is sampled. Readback reflects the new value from the next cycle.
- Reset mid-debounce: the count is discarded and deb returns to 1. If the key is still held low after reset deasserts, a fresh press event occurs DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4.
- Reset, then read addresses 0..3: 0x0000000F, 0, 0, 0, with irq=0.
- in_port[0] driven 1->0 and held; MASK=0x1. Expect deb[0]=0 exactly 5 edges after the sampling edge, EDGE=0x1, COUNT=1, and irq=1 one cycle later. Write EDGE=0x1: EDGE=0 and irq=0.
- Pulse in_port[2] low for 3 cycles, then high. Expect DATA to stay 0xF, EDGE=0 and COUNT unchanged (glitch rejected).
- Drive in_port[1] and in_port[3] low on the same cycle. Expect EDGE=0xA and COUNT to increment by exactly 1. Release both: no EDGE change.
- Preload COUNT to 0xFFFF via 0xFFFF presses (or force in simulation), then one press: expect COUNT=0x0000. Write COUNT together with a press in the same cycle: expect 0. W1C on EDGE bit 0 in the same cycle as a new bit-0 press: expect EDGE[0] to remain 1.
- Hold in_port[0] low and assert reset for 2 cycles midway through debounce. Expect all registers at their reset values, then a press recorded DEBOUNCE_CYCLES+1 edges after reset deasserts.
